// File: rtl/ps2_rx_frame_pkg.sv
// Shared PS/2 definitions: frame geometry, receiver FSM encodings
// and the odd-parity helper used by the receiver and its siblings.
package ps2_rx_frame_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_par_ok(
    input logic [PS2_DATA_BITS:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock glitch filter: the output only moves once FILTER_LEN
// consecutive samples agree; emits a one-cycle falling-edge tick.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ps_c,
  output logic o_fall_tick
);

  logic [FILTER_LEN-1:0] r_sh;
  logic                  r_f;
  logic                  w_f_next;

  always_comb begin
    w_f_next = r_f;
    if (&r_sh)
      w_f_next = 1'b1;
    else if (~|r_sh)
      w_f_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh <= '1;
      r_f  <= 1'b1;
    end else begin
      r_sh <= {r_sh[FILTER_LEN-2:0], i_ps_c};
      r_f  <= w_f_next;
    end
  end

  assign o_fall_tick = r_f & ~w_f_next;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver with parity/stop/timeout checks
// and a show-ahead byte FIFO on a valid/ready output.
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         rx_en,
  input  logic                         ps_c,
  input  logic                         ps_d,
  output logic [PS2_DATA_BITS-1:0]     dout,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         rx_done_tick,
  output logic                         err_parity,
  output logic                         err_frame,
  output logic                         err_timeout,
  output logic                         err_overflow,
  output logic                         busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

  logic                      r_d_meta;
  logic                      r_d_sync;
  logic                      w_fall_tick;
  logic [1:0]                r_state;
  logic [3:0]                r_bit_cnt;
  logic [TW-1:0]             r_tmo;
  // Start bit is never stored; bit 1 is the first data bit.
  logic [PS2_FRAME_BITS-1:1] r_frame;

  logic [PS2_DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [CW-1:0]             r_count;

  logic r_done;
  logic r_par;
  logic r_frm;
  logic r_tmo_err;
  logic r_ovf;

  logic w_chk;
  logic w_par_ok;
  logic w_stop_ok;
  logic w_good;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_tmo_hit;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_ps_c      (ps_c),
    .o_fall_tick (w_fall_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d_meta <= 1'b1;
      r_d_sync <= 1'b1;
    end else begin
      r_d_meta <= ps_d;
      r_d_sync <= r_d_meta;
    end
  end

  assign w_chk     = (r_state == ST_CHECK);
  assign w_par_ok  = odd_par_ok(r_frame[PS2_DATA_BITS+1:1]);
  assign w_stop_ok = r_frame[PS2_FRAME_BITS-1];
  assign w_good    = w_chk & w_par_ok & w_stop_ok;
  assign w_full    = (r_count == FULL);
  assign w_pop     = (r_count != '0) & rx_ready;
  assign w_push    = w_good & (~w_full | w_pop);
  assign w_tmo_hit = (r_state == ST_DATA) & ~w_fall_tick
                   & (r_tmo == TMO_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_tmo     <= '0;
      r_frame   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall_tick & rx_en & ~r_d_sync) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= 4'd9;
            r_tmo     <= '0;
          end
        end
        ST_DATA: begin
          if (w_fall_tick) begin
            r_frame <= {r_d_sync, r_frame[PS2_FRAME_BITS-1:2]};
            r_tmo   <= '0;
            if (r_bit_cnt == 4'd0)
              r_state <= ST_CHECK;
            else
              r_bit_cnt <= r_bit_cnt - 4'd1;
          end else if (w_tmo_hit) begin
            r_state <= ST_IDLE;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_CHECK: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // A push into a full FIFO reuses the slot freed by a same-cycle pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_frame[PS2_DATA_BITS:1];
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push & ~w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop & ~w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done    <= 1'b0;
      r_par     <= 1'b0;
      r_frm     <= 1'b0;
      r_tmo_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done    <= w_push;
      r_par     <= w_chk & ~w_par_ok;
      r_frm     <= w_chk & ~w_stop_ok;
      r_tmo_err <= w_tmo_hit;
      r_ovf     <= w_good & w_full & ~w_pop;
    end
  end

  assign dout         = r_mem[r_rd_ptr];
  assign rx_valid     = (r_count != '0);
  assign fifo_count   = r_count;
  assign rx_done_tick = r_done;
  assign err_parity   = r_par;
  assign err_frame    = r_frm;
  assign err_timeout  = r_tmo_err;
  assign err_overflow = r_ovf;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed + randomized bench for ps2_rx_frame against a queue-based
// model of frame acceptance, error pulses and FIFO contents.
module tb_ps2_rx_frame;

  localparam int FL    = 8;
  localparam int TMO   = 2000;
  localparam int DEPTH = 4;
  localparam int HALF  = 200;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_en;
  logic       ps_c;
  logic       ps_d;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] fifo_count;
  logic       rx_done_tick;
  logic       err_parity;
  logic       err_frame;
  logic       err_timeout;
  logic       err_overflow;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;

  int c_done = 0, c_par = 0, c_frm = 0, c_tmo = 0, c_ovf = 0;
  int e_done = 0, e_par = 0, e_frm = 0, e_tmo = 0, e_ovf = 0;

  logic [7:0] q[$];
  logic [7:0] exp_pop[$];
  logic [7:0] got_q[$];
  int         pop_seen = 0;

  ps2_rx_frame #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_en        (rx_en),
    .ps_c         (ps_c),
    .ps_d         (ps_d),
    .dout         (dout),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .fifo_count   (fifo_count),
    .rx_done_tick (rx_done_tick),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done_tick) c_done <= c_done + 1;
    if (err_parity)   c_par  <= c_par + 1;
    if (err_frame)    c_frm  <= c_frm + 1;
    if (err_timeout)  c_tmo  <= c_tmo + 1;
    if (err_overflow) c_ovf  <= c_ovf + 1;
    if (rx_valid && rx_ready) got_q.push_back(dout);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] b, input int n,
                           input bit glitch, input bit pop_stop);
    for (int i = 0; i < n; i++) begin
      ps_d = b[i];
      if (glitch) begin
        step(100);
        ps_c = 1'b0;
        step(7);
        ps_c = 1'b1;
        step(HALF - 107);
      end else begin
        step(HALF);
      end
      ps_c = 1'b0;
      fall_cyc = cyc;
      if (pop_stop && i == n - 1) begin
        step(9);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(HALF - 10);
      end else begin
        step(HALF);
      end
      ps_c = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par_flip,
                            input bit stop_bit, input bit glitch,
                            input bit pop_stop);
    logic       p;
    logic       par_ok;
    logic [10:0] b;
    p      = ~(^data) ^ par_flip;
    b      = {stop_bit, p, data, 1'b0};
    send_bits(b, 11, glitch, pop_stop);
    ps_d = 1'b1;
    step(20);
    par_ok = ^{data, p};
    if (!par_ok)   e_par++;
    if (!stop_bit) e_frm++;
    if (par_ok && stop_bit) begin
      if (pop_stop && q.size() > 0) exp_pop.push_back(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back(data);
        e_done++;
      end else begin
        e_ovf++;
      end
    end
    if (rx_ready)
      while (q.size() > 0) exp_pop.push_back(q.pop_front());
  endtask

  task automatic check_state(input string tag);
    chk({tag, "/done"}, c_done, e_done);
    chk({tag, "/par"},  c_par,  e_par);
    chk({tag, "/frm"},  c_frm,  e_frm);
    chk({tag, "/tmo"},  c_tmo,  e_tmo);
    chk({tag, "/ovf"},  c_ovf,  e_ovf);
    chk({tag, "/count"}, fifo_count, q.size());
    chk({tag, "/valid"}, rx_valid, q.size() > 0);
    chk({tag, "/busy"},  busy, 0);
    if (q.size() > 0) chk({tag, "/dout"}, dout, q[0]);
    chk({tag, "/npop"}, got_q.size(), exp_pop.size());
    while (pop_seen < got_q.size() && pop_seen < exp_pop.size()) begin
      chk({tag, "/pop"}, got_q[pop_seen], exp_pop[pop_seen]);
      pop_seen++;
    end
  endtask

  task automatic pop_one(input string tag);
    chk({tag, "/head"}, dout, q[0]);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    exp_pop.push_back(q.pop_front());
    step(2);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] rd;
    reset_n  = 1'b0;
    rx_en    = 1'b1;
    ps_c     = 1'b1;
    ps_d     = 1'b1;
    rx_ready = 1'b0;
    step(3);
    chk("rst/dout",  dout, 8'h00);
    chk("rst/count", fifo_count, 0);
    chk("rst/valid", rx_valid, 0);
    chk("rst/busy",  busy, 0);
    chk("rst/pulses", {rx_done_tick, err_parity, err_frame,
                       err_timeout, err_overflow}, 0);
    reset_n = 1'b1;
    step(20);

    // good frame consumed immediately
    rx_ready = 1'b1;
    send_frame(8'hA5, 0, 1, 0, 0);
    rx_ready = 1'b0;
    check_state("t1");

    send_frame(8'h3C, 1, 1, 0, 0);
    check_state("t2");

    send_frame(8'h12, 0, 0, 0, 0);
    check_state("t3a");
    send_frame(8'h12, 0, 1, 0, 0);
    check_state("t3b");

    // short clock glitches must be invisible
    ps_d = 1'b0;
    for (int g = 0; g < 3; g++) begin
      step(1);
      ps_c = 1'b0;
      step(7);
      ps_c = 1'b1;
      step(20);
    end
    ps_d = 1'b1;
    step(5);
    check_state("t4idle");
    send_frame(8'h5A, 0, 1, 1, 0);
    check_state("t4data");
    pop_one("t4p1");
    pop_one("t4p2");

    for (int r = 0; r < 3; r++) begin
      rd = 8'($urandom);
      send_frame(rd, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) != 0, 0, 0);
      check_state("rnd");
      if ($urandom_range(0, 1) == 1 && q.size() > 0) pop_one("rndp");
    end
    while (q.size() > 0) pop_one("drain");

    // partial frame then silence
    send_bits(11'b000_1010_0110, 5, 0, 0);
    while (cyc < fall_cyc + 1990) step(1);
    chk("t5/tmo_early", c_tmo, e_tmo);
    chk("t5/busy_hold", busy, 1);
    while (cyc < fall_cyc + 2030) step(1);
    e_tmo++;
    check_state("t5tmo");
    send_frame(8'h1C, 0, 1, 0, 0);
    check_state("t5rx");

    send_bits(11'b100_0011_0010, 5, 0, 0);
    reset_n = 1'b0;
    step(1);
    chk("t5rst/dout",  dout, 8'h00);
    chk("t5rst/count", fifo_count, 0);
    chk("t5rst/valid", rx_valid, 0);
    chk("t5rst/busy",  busy, 0);
    step(2);
    reset_n = 1'b1;
    q.delete();
    ps_d = 1'b1;
    step(20);
    check_state("t5post");

    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 0, 1, 0, 0);
      check_state("t6fill");
    end
    send_frame(8'h06, 0, 1, 0, 1);
    check_state("t6same");
    while (q.size() > 0) pop_one("t6pop");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
